// File: rtl/sd_in_pio.sv
// Avalon-MM PIO for SD socket status pins: synchronizes, debounces and
// edge-captures each input bit, with a maskable level interrupt.
module sd_in_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] sync2_prev;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] deb_next;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] clear_bits;
  logic [15:0]      cnt      [WIDTH];
  logic [15:0]      cnt_next [WIDTH];
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign unused_wdata = ^writedata;

  // A counter restarts whenever sync2 moves; debounced follows sync2 only on
  // the cycle the counter lands on its saturation value.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = 16'd0;
      if (sync2[i] == sync2_prev[i])
        cnt_next[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 16'd1;
      deb_next[i] = debounced[i];
      if (cnt_next[i] == CNT_MAX && sync2[i] != debounced[i])
        deb_next[i] = sync2[i];
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_event = deb_next & ~debounced;
      1:       edge_event = ~deb_next & debounced;
      default: edge_event = deb_next ^ debounced;
    endcase
  end

  always_comb begin
    clear_bits = '0;
    if (wr_en && address == 2'd3)
      clear_bits = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = debounced;
      2'd1:    rd_mux[WIDTH-1:0] = sync2;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      default: rd_mux[WIDTH-1:0] = edgecapture;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= IN_RESET_VALUE;
      sync2      <= IN_RESET_VALUE;
      sync2_prev <= IN_RESET_VALUE;
      debounced  <= IN_RESET_VALUE;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= 16'd0;
    end else begin
      sync1      <= in_port;
      sync2      <= sync1;
      sync2_prev <= sync2;
      debounced  <= deb_next;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= cnt_next[i];
    end
  end

  // A new edge overrides a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask     <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
      readdata    <= '0;
    end else begin
      if (wr_en && address == 2'd2)
        irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clear_bits) | edge_event;
      irq         <= |(edgecapture & irqmask);
      if (rd_en)
        readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sd_in_pio.sv
// Directed bench for sd_in_pio: an any-edge instance and a rising-edge
// instance share the same bus and pins.
module tb_sd_in_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic [31:0] readdata_r;
  logic        irq;
  logic        irq_r;
  logic [31:0] rd_any;
  logic [31:0] rd_rise;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sd_in_pio dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  sd_in_pio #(.EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_r), .in_port(in_port), .irq(irq_r)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Bus tasks are entered on a falling edge and return on the next one.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d_any,
                          output logic [31:0] d_rise);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    d_any = readdata; d_rise = readdata_r;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_port = 4'hF; address = '0; chipselect = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = '0;
    wait_cycles(2);
    check_output("reset_readdata", readdata, 32'h0);
    check_output("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    wait_cycles(25);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("no_edge_after_reset", rd_any, 32'h0);
    bus_read(2'd0, rd_any, rd_rise);
    check_output("deb_after_reset", rd_any, 32'hF);

    // Falling pin with continuous capture reads: capture lands on edge 18,
    // visible in readdata one edge later.
    in_port[0] = 1'b0; chipselect = 1'b1; read_n = 1'b0; address = 2'd3;
    wait_cycles(18);
    check_output("cap_before_18", readdata, 32'h0);
    wait_cycles(1);
    check_output("cap_at_18", readdata, 32'h1);
    chipselect = 1'b0; read_n = 1'b1;
    check_output("irq_masked", {31'b0, irq}, 32'h0);
    bus_read(2'd0, rd_any, rd_rise);
    check_output("deb_fall", rd_any, 32'hE);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("rise_only_ignores_fall", rd_rise, 32'h0);
    check_output("read_keeps_cap", rd_any, 32'h1);

    in_port[0] = 1'b1;
    wait_cycles(25);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b0;
    wait_cycles(5);
    in_port[0] = 1'b1;
    wait_cycles(25);
    bus_read(2'd0, rd_any, rd_rise);
    check_output("glitch_deb", rd_any, 32'hF);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("glitch_cap", rd_any, 32'h0);
    check_output("glitch_irq", {31'b0, irq}, 32'h0);

    in_port[0] = 1'b0;
    wait_cycles(20);
    check_output("irq_set", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h2);
    wait_cycles(1);
    check_output("irq_other_clear", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check_output("irq_lag", {31'b0, irq}, 32'h1);
    wait_cycles(1);
    check_output("irq_cleared", {31'b0, irq}, 32'h0);

    // Clear of bit 0 lands on the same edge as the rising edge event.
    in_port[0] = 1'b1;
    wait_cycles(17);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("set_wins_any", rd_any, 32'h1);
    check_output("set_wins_rise", rd_rise, 32'h1);
    check_output("set_wins_irq", {31'b0, irq}, 32'h1);

    bus_write(2'd3, 32'hF);
    in_port[1] = 1'b0;
    wait_cycles(20);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("rise_fall_ignored", rd_rise, 32'h0);
    check_output("any_fall_caught", rd_any, 32'h2);
    in_port[1] = 1'b1;
    wait_cycles(20);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("rise_caught", rd_rise, 32'h2);

    // Reset while the counter sits at 8 of a pending fall.
    bus_write(2'd3, 32'hF);
    in_port[0] = 1'b0;
    wait_cycles(11);
    reset = 1'b1; in_port[0] = 1'b1;
    wait_cycles(1);
    check_output("midreset_readdata", readdata, 32'h0);
    check_output("midreset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    wait_cycles(25);
    bus_read(2'd0, rd_any, rd_rise);
    check_output("midreset_deb", rd_any, 32'hF);
    bus_read(2'd1, rd_any, rd_rise);
    check_output("midreset_raw", rd_any, 32'hF);
    bus_read(2'd3, rd_any, rd_rise);
    check_output("midreset_cap", rd_any, 32'h0);

    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    address = 2'd2; writedata = 32'h5;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    check_output("rw_same_addr", readdata, 32'h0);
    bus_read(2'd2, rd_any, rd_rise);
    check_output("mask_written", rd_any, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
